// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, issues one request at a time on a
// req/gnt/rvalid instruction memory port, buffers a single fetched instruction
// for decode, and squashes wrong-path responses after a branch redirect.
module fetch_sequencer #(
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  input  logic        stall_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_FETCH   = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_DISCARD = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        instr_valid_q, instr_valid_d;

  logic        req;
  logic        accept;
  logic        consume;

  // Request only while the buffer is empty or being drained this cycle, so a
  // response can never land on top of an unconsumed instruction.
  always_comb begin
    req     = (state_q == S_FETCH) && !(instr_valid_q && stall_i);
    accept  = req && imem_gnt_i;
    consume = instr_valid_q && !stall_i;
  end

  // Next-state logic: normal sequencing first, then redirect overrides it.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_pc_d      = req_pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q && !consume;

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (accept) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + 32'd4;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid_i) begin
          instr_d       = imem_rdata_i;
          instr_pc_d    = req_pc_q;
          instr_valid_d = 1'b1;
          state_d       = S_FETCH;
        end
      end
      default: begin
        // Wrong-path response: drop it and resume fetching.
        if (imem_rvalid_i) begin
          state_d = S_FETCH;
        end
      end
    endcase

    if (branch_i) begin
      pc_d          = branch_target_i & 32'hFFFF_FFFC;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = 1'b0;
      case (state_q)
        S_IDLE:  state_d = S_FETCH;
        S_FETCH: state_d = accept ? S_DISCARD : S_FETCH;
        default: state_d = imem_rvalid_i ? S_FETCH : S_DISCARD;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_VAL;
      req_pc_q      <= RESET_VAL;
      instr_q       <= 32'd0;
      instr_pc_q    <= 32'd0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_pc_q      <= req_pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign imem_req_o    = req;
  assign imem_addr_o   = pc_q;
  assign instr_valid_o = instr_valid_q;
  assign instr_o       = instr_q;
  assign instr_pc_o    = instr_pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a behavioural imem responder, a queue of
// expected (correct-path) instruction addresses popped on every decode
// consume, and point checks on request/address/buffer outputs.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        branch_i;
  logic [31:0] branch_target_i;
  logic        stall_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;

  // Second instance exercising the PC wrap from the top of the address space.
  logic        rst2;
  logic        rv2;
  logic [31:0] rd2;
  logic        req2;
  logic [31:0] addr2;
  logic        v2;
  logic [31:0] i2;
  logic [31:0] p2;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .branch_i        (branch_i),
    .branch_target_i (branch_target_i),
    .stall_i         (stall_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_gnt_i      (imem_gnt_i),
    .imem_rvalid_i   (imem_rvalid_i),
    .imem_rdata_i    (imem_rdata_i),
    .instr_valid_o   (instr_valid_o),
    .instr_o         (instr_o),
    .instr_pc_o      (instr_pc_o)
  );

  fetch_sequencer #(.RESET_VAL(32'hFFFF_FFFC)) dut_wrap (
    .clk             (clk),
    .rst             (rst2),
    .branch_i        (1'b0),
    .branch_target_i (32'd0),
    .stall_i         (1'b0),
    .imem_req_o      (req2),
    .imem_addr_o     (addr2),
    .imem_gnt_i      (1'b1),
    .imem_rvalid_i   (rv2),
    .imem_rdata_i    (rd2),
    .instr_valid_o   (v2),
    .instr_o         (i2),
    .instr_pc_o      (p2)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Bench-side stimulus knobs and imem responder state.
  logic        st;
  logic        g;
  int          lat;
  logic        pend_valid;
  logic [31:0] pend_addr;
  int          pend_cnt;
  logic [31:0] exp_q[$];
  int          fv;
  int          ncall;

  // Outputs sampled mid-cycle by cyc().
  logic        s_req;
  logic [31:0] s_addr;
  logic        s_valid;
  logic [31:0] s_instr;
  logic [31:0] s_pc;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  // One clock cycle: drive inputs, sample outputs, score any consume, advance
  // the imem responder.
  task automatic cyc(input logic br, input logic [31:0] tgt);
    logic acc;
    logic [31:0] e;
    branch_i        = br;
    branch_target_i = tgt;
    stall_i         = st;
    imem_gnt_i      = g;
    if (!rst && pend_valid && pend_cnt == 0) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = memword(pend_addr);
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;
    end
    #1;
    s_req   = imem_req_o;
    s_addr  = imem_addr_o;
    s_valid = instr_valid_o;
    s_instr = instr_o;
    s_pc    = instr_pc_o;
    acc     = s_req && g;
    if (!rst) begin
      chk("single_outstanding", {31'd0, acc && pend_valid}, 32'd0);
      if (s_valid && !st) begin
        chk("unexpected_instr", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          $display("consume pc=%h instr=%h", s_pc, s_instr);
          chk("instr_pc", s_pc, e);
          chk("instr_word", s_instr, memword(e));
        end
      end
    end
    @(posedge clk);
    if (rst) begin
      pend_valid = 1'b0;
    end else begin
      if (imem_rvalid_i) pend_valid = 1'b0;
      else if (pend_valid) pend_cnt--;
      if (acc) begin
        pend_valid = 1'b1;
        pend_addr  = s_addr;
        pend_cnt   = lat - 1;
      end
    end
    @(negedge clk);
    branch_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    st  = 1'b0;
    g   = 1'b1;
    lat = 1;
    fv  = 0;
    cyc(1'b0, 32'd0);
    cyc(1'b0, 32'd0);
    chk("rst_req", {31'd0, s_req}, 32'd0);
    chk("rst_valid", {31'd0, s_valid}, 32'd0);
    chk("rst_instr", s_instr, 32'd0);
    chk("rst_instr_pc", s_pc, 32'd0);
    chk("rst_addr", s_addr, 32'd0);
    rst = 1'b0;
  endtask

  task automatic run_until_empty(input int bound);
    ncall = 0;
    while (exp_q.size() != 0 && ncall < bound) begin
      cyc(1'b0, 32'd0);
      ncall++;
      if (s_valid && fv == 0) fv = ncall;
    end
    chk("drain_timeout", {31'd0, exp_q.size() == 0}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1; rv2 = 1'b0; rd2 = 32'd0;
    branch_i = 1'b0; branch_target_i = 32'd0; stall_i = 1'b0;
    imem_gnt_i = 1'b1; imem_rvalid_i = 1'b0; imem_rdata_i = 32'd0;
    pend_valid = 1'b0; pend_addr = 32'd0; pend_cnt = 0;

    // Streaming fetch, zero stall, 1-cycle memory.
    do_reset();
    exp_q.push_back(32'd0);  exp_q.push_back(32'd4); exp_q.push_back(32'd8);
    exp_q.push_back(32'd12); exp_q.push_back(32'd16);
    run_until_empty(40);
    chk("first_valid_cycle", fv, 4);
    chk("stream_cycles", ncall, 12);

    // Decode stall with a full buffer, then release.
    do_reset();
    exp_q.push_back(32'd0); exp_q.push_back(32'd4);
    cyc(1'b0, 32'd0); cyc(1'b0, 32'd0); cyc(1'b0, 32'd0);
    st = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 32'd0);
      chk("stall_req", {31'd0, s_req}, 32'd0);
      chk("stall_valid", {31'd0, s_valid}, 32'd1);
      chk("stall_pc", s_pc, 32'd0);
      chk("stall_instr", s_instr, memword(32'd0));
    end
    st = 1'b0;
    cyc(1'b0, 32'd0);
    chk("release_req", {31'd0, s_req}, 32'd1);
    chk("release_addr", s_addr, 32'd4);
    run_until_empty(20);

    // Redirect while waiting; the in-flight word must be dropped.
    do_reset();
    lat = 4;
    exp_q.push_back(32'h100);
    cyc(1'b0, 32'd0); cyc(1'b0, 32'd0);
    cyc(1'b1, 32'h100);
    cyc(1'b0, 32'd0);
    chk("discard_req", {31'd0, s_req}, 32'd0);
    chk("discard_valid", {31'd0, s_valid}, 32'd0);
    cyc(1'b0, 32'd0); cyc(1'b0, 32'd0);
    lat = 1;
    cyc(1'b0, 32'd0);
    chk("redirect_req", {31'd0, s_req}, 32'd1);
    chk("redirect_addr", s_addr, 32'h100);
    run_until_empty(20);

    // Redirect coincident with grant, then again while discarding.
    do_reset();
    lat = 3;
    exp_q.push_back(32'h200);
    cyc(1'b0, 32'd0);
    cyc(1'b1, 32'h80);
    cyc(1'b1, 32'h200);
    chk("discard2_req", {31'd0, s_req}, 32'd0);
    cyc(1'b0, 32'd0); cyc(1'b0, 32'd0);
    lat = 1;
    cyc(1'b0, 32'd0);
    chk("redirect2_req", {31'd0, s_req}, 32'd1);
    chk("redirect2_addr", s_addr, 32'h200);
    run_until_empty(20);

    // Reset in the middle of an outstanding fetch.
    do_reset();
    exp_q.push_back(32'd0);
    cyc(1'b0, 32'd0); cyc(1'b0, 32'd0); cyc(1'b0, 32'd0);
    lat = 5;
    cyc(1'b0, 32'd0);
    cyc(1'b0, 32'd0);
    chk("wait_req", {31'd0, s_req}, 32'd0);
    chk("wait_instr_held", s_instr, memword(32'd0));
    rst = 1'b1;
    cyc(1'b0, 32'd0);
    rst = 1'b0;
    cyc(1'b0, 32'd0);
    chk("midrst_req", {31'd0, s_req}, 32'd0);
    chk("midrst_valid", {31'd0, s_valid}, 32'd0);
    chk("midrst_instr", s_instr, 32'd0);
    chk("midrst_pc", s_pc, 32'd0);
    chk("midrst_addr", s_addr, 32'd0);
    lat = 1;
    exp_q.push_back(32'd0);
    run_until_empty(20);

    // Grant withheld: address held; redirect to an unaligned target in FETCH.
    do_reset();
    g = 1'b0;
    cyc(1'b0, 32'd0);
    cyc(1'b0, 32'd0);
    chk("nognt_req", {31'd0, s_req}, 32'd1);
    chk("nognt_addr", s_addr, 32'd0);
    cyc(1'b0, 32'd0);
    chk("nognt_addr_hold", s_addr, 32'd0);
    cyc(1'b1, 32'h103);
    cyc(1'b0, 32'd0);
    chk("align_req", {31'd0, s_req}, 32'd1);
    chk("align_addr", s_addr, 32'h100);
    g = 1'b1;
    exp_q.push_back(32'h100);
    run_until_empty(20);

    // PC wrap on the second instance.
    rst2 = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("wrap_rst_addr", addr2, 32'hFFFF_FFFC);
    chk("wrap_rst_valid", {31'd0, v2}, 32'd0);
    rst2 = 1'b0;
    @(negedge clk);
    chk("wrap_req0", {31'd0, req2}, 32'd1);
    chk("wrap_addr0", addr2, 32'hFFFF_FFFC);
    @(negedge clk);
    rv2 = 1'b1; rd2 = 32'h1234_5678;
    @(negedge clk);
    rv2 = 1'b0;
    $display("wrap instr pc=%h instr=%h next_addr=%h", p2, i2, addr2);
    chk("wrap_valid", {31'd0, v2}, 32'd1);
    chk("wrap_pc", p2, 32'hFFFF_FFFC);
    chk("wrap_instr", i2, 32'h1234_5678);
    chk("wrap_addr1", addr2, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
